// File: rtl/mac_pkg.sv
// Shared types for the staged_mac front end: default widths, the
// {weight, activation} beat layout and the operand-feeder FSM states.
package mac_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int LEN_BITS_DEF   = 16;
    localparam int ID_BITS_DEF    = 8;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0] weight;
        logic [DATA_WIDTH_DEF-1:0] activation;
    } mac_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIAS = 2'd1,
        ST_PAIR = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer for an AXI-Stream payload.
// Upstream ready depends only on the occupancy register, never on downstream ready.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // Promote the spare entry only if it actually holds a beat
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with exactly one beat held: head drains, new beat replaces it
                    r_head <= i_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Joins weight and activation streams into framed {weight, activation} jobs
// for staged_mac, with an optional bias beat as the accumulator-init beat.
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_BITS   = LEN_BITS_DEF,
    parameter int ID_BITS    = ID_BITS_DEF
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    CFG_VALID,
    output logic                    CFG_READY,
    input  logic [LEN_BITS-1:0]     CFG_LEN,
    input  logic [DATA_WIDTH-1:0]   CFG_BIAS,
    input  logic                    CFG_BIAS_EN,
    input  logic [ID_BITS-1:0]      CFG_ID,
    input  logic [DATA_WIDTH-1:0]   SW_AXIS_TDATA,
    input  logic                    SW_AXIS_TVALID,
    output logic                    SW_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0]   SA_AXIS_TDATA,
    input  logic                    SA_AXIS_TVALID,
    output logic                    SA_AXIS_TREADY,
    output logic [2*DATA_WIDTH-1:0] MO_AXIS_TDATA,
    output logic                    MO_AXIS_TVALID,
    input  logic                    MO_AXIS_TREADY,
    output logic                    MO_AXIS_TLAST,
    output logic                    MO_AXIS_TUSER,
    output logic [ID_BITS-1:0]      MO_AXIS_TID,
    output logic                    BUSY
);

    localparam int PW = 2*DATA_WIDTH + 2 + ID_BITS;

    feeder_state_t           r_state, w_state_next;
    logic [LEN_BITS-1:0]     r_remaining, w_remaining_next;
    logic                    r_first, w_first_next;
    logic [DATA_WIDTH-1:0]   r_bias;
    logic                    r_bias_en;
    logic [ID_BITS-1:0]      r_id;

    logic                    w_cfg_fire;
    logic                    w_join;
    logic                    w_skid_ready;
    logic                    w_push;
    logic [2*DATA_WIDTH-1:0] w_push_data;
    logic                    w_push_last;
    logic                    w_push_user;
    logic [DATA_WIDTH-1:0]   w_bias_word;
    logic [PW-1:0]           w_skid_out;

    // Gated by reset so nothing is consumed while ARESET is high
    assign CFG_READY      = (r_state == ST_IDLE) & ~ARESET;
    assign w_cfg_fire     = CFG_VALID & CFG_READY;
    assign w_join         = (r_state == ST_PAIR) & SW_AXIS_TVALID & SA_AXIS_TVALID
                          & w_skid_ready & ~ARESET;
    assign SW_AXIS_TREADY = w_join;
    assign SA_AXIS_TREADY = w_join;
    assign BUSY           = (r_state != ST_IDLE);
    assign w_bias_word    = r_bias_en ? r_bias : {DATA_WIDTH{1'b0}};

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_first_next     = r_first;
        w_push           = 1'b0;
        w_push_data      = '0;
        w_push_last      = 1'b0;
        w_push_user      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_fire) begin
                    w_remaining_next = CFG_LEN;
                    w_first_next     = 1'b1;
                    // Zero-length jobs still emit one init beat so the MAC produces a result
                    w_state_next     = (CFG_BIAS_EN || (CFG_LEN == '0)) ? ST_BIAS : ST_PAIR;
                end
            end
            ST_BIAS: begin
                if (w_skid_ready) begin
                    w_push       = 1'b1;
                    w_push_data  = {{DATA_WIDTH{1'b0}}, w_bias_word};
                    w_push_user  = 1'b1;
                    w_push_last  = (r_remaining == '0);
                    w_first_next = 1'b0;
                    w_state_next = (r_remaining != '0) ? ST_PAIR : ST_IDLE;
                end
            end
            ST_PAIR: begin
                if (w_join) begin
                    w_push           = 1'b1;
                    w_push_data      = {SW_AXIS_TDATA, SA_AXIS_TDATA};
                    w_push_user      = r_first;
                    w_push_last      = (r_remaining == LEN_BITS'(1));
                    w_remaining_next = r_remaining - LEN_BITS'(1);
                    w_first_next     = 1'b0;
                    if (r_remaining == LEN_BITS'(1)) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_bias      <= '0;
            r_bias_en   <= 1'b0;
            r_id        <= '0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_first     <= w_first_next;
            if (w_cfg_fire) begin
                r_bias    <= CFG_BIAS;
                r_bias_en <= CFG_BIAS_EN;
                r_id      <= CFG_ID;
            end
        end
    end

    axis_skid_buffer #(
        .WIDTH (PW)
    ) u_skid (
        .clk     (ACLK),
        .srst    (ARESET),
        .i_data  ({w_push_data, w_push_last, w_push_user, r_id}),
        .i_valid (w_push),
        .o_ready (w_skid_ready),
        .o_data  (w_skid_out),
        .o_valid (MO_AXIS_TVALID),
        .i_ready (MO_AXIS_TREADY)
    );

    assign MO_AXIS_TDATA = w_skid_out[PW-1 -: 2*DATA_WIDTH];
    assign MO_AXIS_TLAST = w_skid_out[ID_BITS+1];
    assign MO_AXIS_TUSER = w_skid_out[ID_BITS];
    assign MO_AXIS_TID   = w_skid_out[ID_BITS-1:0];

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Randomized bench for mac_operand_feeder: a job-level model predicts the
// framed output beat stream, which is compared beat by beat.
`timescale 1ns/1ps
module tb_mac_operand_feeder;
    import mac_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        CFG_VALID = 1'b0;
    logic        CFG_READY;
    logic [15:0] CFG_LEN = '0;
    logic [31:0] CFG_BIAS = '0;
    logic        CFG_BIAS_EN = 1'b0;
    logic [7:0]  CFG_ID = '0;
    logic [31:0] SW_AXIS_TDATA = '0;
    logic        SW_AXIS_TVALID = 1'b0;
    logic        SW_AXIS_TREADY;
    logic [31:0] SA_AXIS_TDATA = '0;
    logic        SA_AXIS_TVALID = 1'b0;
    logic        SA_AXIS_TREADY;
    logic [63:0] MO_AXIS_TDATA;
    logic        MO_AXIS_TVALID;
    logic        MO_AXIS_TREADY = 1'b0;
    logic        MO_AXIS_TLAST;
    logic        MO_AXIS_TUSER;
    logic [7:0]  MO_AXIS_TID;
    logic        BUSY;

    always #5 ACLK = ~ACLK;

    mac_operand_feeder dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .CFG_VALID      (CFG_VALID),
        .CFG_READY      (CFG_READY),
        .CFG_LEN        (CFG_LEN),
        .CFG_BIAS       (CFG_BIAS),
        .CFG_BIAS_EN    (CFG_BIAS_EN),
        .CFG_ID         (CFG_ID),
        .SW_AXIS_TDATA  (SW_AXIS_TDATA),
        .SW_AXIS_TVALID (SW_AXIS_TVALID),
        .SW_AXIS_TREADY (SW_AXIS_TREADY),
        .SA_AXIS_TDATA  (SA_AXIS_TDATA),
        .SA_AXIS_TVALID (SA_AXIS_TVALID),
        .SA_AXIS_TREADY (SA_AXIS_TREADY),
        .MO_AXIS_TDATA  (MO_AXIS_TDATA),
        .MO_AXIS_TVALID (MO_AXIS_TVALID),
        .MO_AXIS_TREADY (MO_AXIS_TREADY),
        .MO_AXIS_TLAST  (MO_AXIS_TLAST),
        .MO_AXIS_TUSER  (MO_AXIS_TUSER),
        .MO_AXIS_TID    (MO_AXIS_TID),
        .BUSY           (BUSY)
    );

    typedef struct {
        int          len;
        bit          bias_en;
        logic [31:0] bias;
        logic [7:0]  id;
    } job_t;

    typedef struct {
        mac_beat_t  data;
        bit         last;
        bit         user;
        logic [7:0] id;
    } beat_t;

    job_t        jobs[$];
    logic [31:0] wsrc[$];
    logic [31:0] asrc[$];
    beat_t       exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Job-level model: beats = optional init beat, then the pairs in stream order.
    task automatic add_job(input int len, input bit ben, input logic [31:0] bias,
                           input logic [7:0] id, input bit seq);
        job_t        j;
        beat_t       b;
        logic [31:0] w;
        logic [31:0] a;
        j.len = len; j.bias_en = ben; j.bias = bias; j.id = id;
        jobs.push_back(j);
        if (ben || len == 0) begin
            b.data.weight     = 32'h0;
            b.data.activation = ben ? bias : 32'h0;
            b.user = 1'b1;
            b.last = (len == 0);
            b.id   = id;
            exp_q.push_back(b);
        end
        for (int k = 0; k < len; k++) begin
            w = seq ? 32'(k + 1) : $urandom;
            a = seq ? 32'(k + 4) : $urandom;
            wsrc.push_back(w);
            asrc.push_back(a);
            b.data.weight     = w;
            b.data.activation = a;
            b.user = (k == 0) && !(ben);
            b.last = (k == len - 1);
            b.id   = id;
            exp_q.push_back(b);
        end
        $display("job: len=%0d bias_en=%0d bias=%08h id=%02h", len, ben, bias, id);
    endtask

    task automatic run(input int ready_pct, input int valid_pct, input int w_hold_init,
                       input int abort_joins, input bit chk_lat, input bit chk_thr);
        int           cyc = 0;
        int           joins = 0;
        int           first_join = -1;
        int           last_join = -1;
        int           first_valid = -1;
        int           w_hold = w_hold_init;
        int           nbeats = exp_q.size();
        int           got = 0;
        bit           wv = 1'b0;
        bit           av = 1'b0;
        bit           stalled = 1'b0;
        logic [73:0]  held = '0;
        beat_t        b;
        while (got < nbeats && cyc < 3000) begin
            @(negedge ACLK);
            CFG_VALID = (jobs.size() > 0);
            if (jobs.size() > 0) begin
                CFG_LEN     = 16'(jobs[0].len);
                CFG_BIAS    = jobs[0].bias;
                CFG_BIAS_EN = jobs[0].bias_en;
                CFG_ID      = jobs[0].id;
            end
            if (!wv && wsrc.size() > 0 && w_hold == 0 && $urandom_range(99) < valid_pct) wv = 1'b1;
            if (!av && asrc.size() > 0 && $urandom_range(99) < valid_pct) av = 1'b1;
            if (w_hold > 0) w_hold--;
            SW_AXIS_TVALID = wv;
            SW_AXIS_TDATA  = wv ? wsrc[0] : $urandom;
            SA_AXIS_TVALID = av;
            SA_AXIS_TDATA  = av ? asrc[0] : $urandom;
            MO_AXIS_TREADY = ($urandom_range(99) < ready_pct);
            #1;
            if (stalled)
                check("stall_hold", {MO_AXIS_TVALID, MO_AXIS_TDATA, MO_AXIS_TLAST, MO_AXIS_TUSER, MO_AXIS_TID},
                      {1'b1, held});
            stalled = 1'b0;
            if (MO_AXIS_TVALID) begin
                if (first_valid < 0) first_valid = cyc;
                if (MO_AXIS_TREADY) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        b = exp_q.pop_front();
                        check("tdata", MO_AXIS_TDATA, b.data);
                        check("tlast", MO_AXIS_TLAST, b.last);
                        check("tuser", MO_AXIS_TUSER, b.user);
                        check("tid", MO_AXIS_TID, b.id);
                        $display("beat: tdata=%016h last=%0d user=%0d tid=%02h",
                                 MO_AXIS_TDATA, MO_AXIS_TLAST, MO_AXIS_TUSER, MO_AXIS_TID);
                        got++;
                    end
                end else begin
                    stalled = 1'b1;
                    held = {MO_AXIS_TDATA, MO_AXIS_TLAST, MO_AXIS_TUSER, MO_AXIS_TID};
                end
            end
            if (SW_AXIS_TREADY || SA_AXIS_TREADY)
                check("join", {SW_AXIS_TREADY, SA_AXIS_TREADY, SW_AXIS_TVALID, SA_AXIS_TVALID}, 4'b1111);
            if (CFG_VALID && CFG_READY) void'(jobs.pop_front());
            if (SW_AXIS_TVALID && SW_AXIS_TREADY) begin
                void'(wsrc.pop_front());
                wv = 1'b0;
                joins++;
                if (first_join < 0) first_join = cyc;
                last_join = cyc;
            end
            if (SA_AXIS_TVALID && SA_AXIS_TREADY) begin
                void'(asrc.pop_front());
                av = 1'b0;
            end
            cyc++;
            if (abort_joins > 0 && joins == abort_joins) break;
        end
        if (abort_joins == 0) begin
            check("beats_out", got, nbeats);
            check("streams_drained", wsrc.size() + asrc.size(), 0);
        end
        if (chk_lat) check("latency", first_valid, first_join + 1);
        if (chk_thr) check("join_burst", last_join - first_join, joins - 1);
    endtask

    task automatic apply_reset();
        @(negedge ACLK);
        ARESET = 1'b1;
        CFG_VALID = 1'b0;
        SW_AXIS_TVALID = 1'b0;
        SA_AXIS_TVALID = 1'b0;
        MO_AXIS_TREADY = 1'b0;
        jobs.delete(); wsrc.delete(); asrc.delete(); exp_q.delete();
        @(negedge ACLK);
        check("rst_mo_valid", MO_AXIS_TVALID, 0);
        check("rst_cfg_ready", CFG_READY, 0);
        check("rst_in_ready", {SW_AXIS_TREADY, SA_AXIS_TREADY}, 0);
        check("rst_busy", BUSY, 0);
        check("rst_payload", {MO_AXIS_TDATA, MO_AXIS_TLAST, MO_AXIS_TUSER, MO_AXIS_TID}, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("post_rst_cfg_ready", CFG_READY, 1);
        check("post_rst_busy", BUSY, 0);
        $display("reset: applied and released");
    endtask

    initial begin
        apply_reset();

        add_job(3, 1'b0, 32'h0, 8'h05, 1'b1);
        run(100, 100, 0, 0, 1'b1, 1'b1);

        add_job(2, 1'b1, 32'h0001_8000, 8'h11, 1'b0);
        run(100, 100, 0, 0, 1'b0, 1'b0);

        add_job(1, 1'b0, 32'h0, 8'h21, 1'b0);
        run(100, 100, 5, 0, 1'b0, 1'b0);

        add_job(8, 1'b0, 32'h0, 8'h33, 1'b0);
        run(100, 100, 0, 0, 1'b0, 1'b1);
        add_job(8, 1'b0, 32'h0, 8'h34, 1'b0);
        run(50, 100, 0, 0, 1'b0, 1'b0);

        add_job(0, 1'b0, 32'h1234_5678, 8'h40, 1'b0);
        add_job(0, 1'b1, 32'hFFFF_8000, 8'h41, 1'b0);
        for (int i = 0; i < 6; i++)
            add_job($urandom_range(5), 1'($urandom_range(1)), $urandom, 8'(8'h50 + i), 1'b0);
        run(60, 70, 0, 0, 1'b0, 1'b0);

        add_job(6, 1'b0, 32'h0, 8'h07, 1'b0);
        run(100, 100, 0, 2, 1'b0, 1'b0);
        apply_reset();
        add_job(3, 1'b1, $urandom, 8'h09, 1'b0);
        run(80, 90, 0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Upstream stage of staged_mac: joins a weight AXI-Stream and an activation AXI-Stream into the MAC's 64-bit {weight, activation} input beat.
- Frames each dot-product job with TUSER, TLAST and TID so the MAC produces exactly one output per job.
- Optionally injects a per-job bias as the accumulator-init beat.
- A registered 2-entry skid buffer decouples input TREADYs from MO_AXIS_TREADY.

Parameters:
- DATA_WIDTH, 32, operand width (weight, activation, bias); signed Q16.16 in the current MAC.
- LEN_BITS, 16, width of the job-length field.
- ID_BITS, 8, width of the job ID / TID.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset, synchronous, active-high
- CFG_VALID  in  1  job descriptor valid
- CFG_READY  out  1  descriptor accepted when CFG_VALID & CFG_READY
- CFG_LEN  in  LEN_BITS  number of weight/activation pairs in the job
- CFG_BIAS  in  DATA_WIDTH  bias value, signed
- CFG_BIAS_EN  in  1  1 = emit bias init beat before the pairs
- CFG_ID  in  ID_BITS  job ID, copied to TID
- SW_AXIS_TDATA / TVALID / TREADY  in/in/out  DATA_WIDTH/1/1  weight stream
- SA_AXIS_TDATA / TVALID / TREADY  in/in/out  DATA_WIDTH/1/1  activation stream
- MO_AXIS_TDATA  out  2*DATA_WIDTH  {weight, activation}
- MO_AXIS_TVALID / TREADY  out/in  1/1  output handshake
- MO_AXIS_TLAST  out  1  final beat of job
- MO_AXIS_TUSER  out  1  accumulator-init beat (first beat of job only)
- MO_AXIS_TID  out  ID_BITS  job ID
- BUSY  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock ACLK; reset ARESET is synchronous, active-high.
- Reset values: all TVALID/TREADY = 0, CFG_READY = 0, BUSY = 0, MO_AXIS_TDATA/TLAST/TUSER/TID = 0. FSM goes to IDLE, counters 0, skid emptied.
- Reset mid-job: partial job is discarded and in-flight beats are dropped. No input is consumed while ARESET = 1.
- FSM states: IDLE, BIAS, PAIR.
- IDLE:
  - CFG_READY = 1. On descriptor handshake, latch LEN, BIAS, BIAS_EN, ID; set remaining = LEN; set first = 1.
  - Next state: BIAS if BIAS_EN, or if LEN = 0; otherwise PAIR.
- BIAS: when the skid has space, push one beat and clear first.
  - Beat: TDATA = {0, bias} (or {0,0} when BIAS_EN = 0), TUSER = 1, TLAST = (remaining == 0).
  - Next state: PAIR if remaining > 0, else IDLE.
  - Result: MAC accumulator starts at bias + 0*bias = bias.
- PAIR (join):
  - SW_AXIS_TREADY = SA_AXIS_TREADY = SW_AXIS_TVALID & SA_AXIS_TVALID & skid_not_full. The two streams are always consumed in the same cycle, never one alone.
  - Each join pushes {w, a}, TUSER = first, TLAST = (remaining == 1), then remaining decrements and first clears.
  - Last join returns the FSM to IDLE.
- Outside PAIR, both input TREADYs = 0.
- LEN = 0 with BIAS_EN = 0: exactly one beat {0,0}, TUSER = 1, TLAST = 1, so the MAC still emits 0 for that job.
- Beats per job = LEN + BIAS_EN (minimum 1). TID is constant within a job.
- Latency: MO_AXIS_TVALID rises one cycle after the input join (or bias push) into an empty skid.
- Skid buffer:
  - Sustains 1 beat/cycle with MO_AXIS_TREADY held high.
  - skid_not_full comes from a register only; it has no combinational path from MO_AXIS_TREADY.
  - While TVALID & !TREADY, MO_AXIS_* must hold stable.
- Next descriptor is accepted in the cycle after the last beat is pushed. Jobs pipeline back-to-back through the skid.
- No arithmetic. Data passes bit-exact; bias is not resized.

Decomposition:
- Package mac_pkg holds:
  - DATA_WIDTH, LEN_BITS, ID_BITS defaults;
  - typedef of the {weight, activation} beat struct;
  - FSM state enum.
- Sub-module axis_skid_buffer (payload width parameter; TDATA+TLAST+TUSER+TID packed). It is reusable on the staged_mac output.

Test Plan:
- LEN = 3, BIAS_EN = 0, ID = 0x05, w = {1,2,3}, a = {4,5,6}, MO ready → 3 beats {1,4},{2,5},{3,6}; TUSER = 1,0,0; TLAST = 0,0,1; TID = 0x05.
- LEN = 2, BIAS_EN = 1, BIAS = 0x00018000 → beats {0,0x00018000} (TUSER = 1), then 2 pairs, TLAST on 3rd. Feeding staged_mac gives bias + Σw·a.
- Activation valid 5 cycles before weight → no TREADY pulses until both are valid, then a single joint handshake; no beat duplicated or dropped.
- LEN = 8, MO_AXIS_TREADY random 50% → output sequence identical to the ready-high run; TDATA stable whenever stalled.
- LEN = 0, BIAS_EN = 0 → one beat {0,0}, TUSER = 1, TLAST = 1. LEN = 0, BIAS_EN = 1 → one bias beat, TLAST = 1.
- ARESET asserted after 2 of 6 pairs → all valids 0 next cycle, CFG_READY = 1 after release, next job ID = 0x09 runs cleanly.
